sar_adc_ctrl: RTL and testbench
===============================

// Module: sar_adc_ctrl
// PURPOSE
//  Digital successive-approximation controller for a differential charge-redistribution SAR ADC.
//  - Receives a toggle-coded start-of-conversion (SOC), drives the analog macro
//    (sample, comparator clock, capacitor switches) and runs a binary search.
//  - Returns the code with toggle-coded end-of-conversion / error / warning events.
//  - Sits between the f100m_clk digital domain and the ms_sar_* analog macro.
// PARAMETERS
//  NSTEP      10  number of conversion bits / SAR steps (code width)
//  STEP_SIZE  4   f100m_clk cycles per sample phase and per SAR step; even, >=4
// PORTS
//  f100m_clk      in   1      100 MHz clock
//  rstb           in   1      reset, asynchronous, active-low
//  atpg           in   1      scan mode: forces all analog-facing outputs to 0
//  sar_soc        in   1      SOC toggle: each transition requests one conversion
//  sar_eoc        out  1      EOC toggle: flips once per finished conversion
//  sar_err        out  1      error toggle: flips per step with invalid comparator result
//  sar_warn       out  1      warning toggle: flips per late comparator or ignored SOC
//  sar_code       out  NSTEP  last conversion result, offset binary
//  ms_sar_dh      in   1      comparator: input above trial level
//  ms_sar_dl      in   1      comparator: input below trial level
//  ms_sar_rdy     in   1      comparator decision valid
//  ms_sar_clock   out  1      comparator strobe
//  ms_sar_sample  out  1      sampling switch enable
//  ms_sar_sw      out  NSTEP  capacitor bit i to vrefp
//  ms_sar_swb     out  NSTEP  capacitor bit i to vrefm
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; SOC synchroniser cleared.
//  - SOC path: sar_soc -> 2-FF sync -> XOR with delayed copy = 1-cycle start pulse.
//  - FSM: IDLE -> SAMPLE -> CONV -> DONE -> IDLE.
//  - SAMPLE: ms_sar_sample=1 for STEP_SIZE cycles; sw=swb=0; result register cleared.
//  - CONV: NSTEP steps, MSB first, index k; step cycle counter c = 0..STEP_SIZE-1.
//    - c=0: trial bit k set in the result register.
//    - ms_sar_sw = result register; ms_sar_swb = ~ms_sar_sw.
//    - ms_sar_clock=1 for c in [1, STEP_SIZE/2], otherwise 0.
//    - c=STEP_SIZE-1: sample dh/dl/rdy; bit k <= dh (keep 1 if dh, clear if not).
//    - rdy=0 at that edge: toggle sar_warn; bit k cleared.
//    - rdy=1 and dh==dl: toggle sar_err; bit k cleared.
//  - DONE (1 cycle): sar_code <= result; sar_eoc toggles on the next edge;
//    sw/swb return to 0; FSM -> IDLE.
//  - Latency: start pulse to sar_eoc flip = STEP_SIZE*(NSTEP+1)+2 cycles
//    (46 for the defaults); SOC toggle to start pulse = 3 cycles.
//  - A start pulse outside IDLE is ignored: toggle sar_warn, running conversion unaffected.
//  - A start pulse on the DONE cycle counts as outside IDLE.
//  - sar_code holds its value until the next DONE. Asynchronous reset mid-conversion
//    aborts; no eoc toggle.
//  - atpg=1 forces ms_sar_sample, ms_sar_clock, sw and swb to 0.
//    FSM and toggles keep running.
//  - Code mapping: all 1s = most positive differential input; 2^(NSTEP-1) = zero differential.
// STRUCTURE
//  - Package sar_pkg holds:
//    - typedef enum {IDLE, SAMPLE, CONV, DONE} sar_state_t;
//    - localparam default NSTEP and STEP_SIZE;
//    - step/cycle counter width functions ($clog2).
//  - One sub-module, sar_toggle_sync: 2-FF toggle synchroniser with pulse output.
//  - Event toggles are plain flops inside sar_adc_ctrl.
// TESTING
//  - Reset: rstb=0 -> all outputs 0.
//    After release, no activity until sar_soc toggles.
//  - Always-high comparator (dh=1, dl=0, rdy=1), one SOC toggle:
//    - sar_eoc flips 49 cycles after the SOC toggle;
//    - sar_code=10'h3FF; err and warn unchanged.
//  - Comparator model at 0 V differential input against a 1 V reference span
//    (dh = trial level below input):
//    - sar_code=10'h200;
//    - sw sequence 200,300/100 ... checked step by step; swb == ~sw throughout CONV.
//  - rdy=0 on step 3 only, dh=1 otherwise: one sar_warn flip; code=10'h3FF with bit 6 cleared (10'h3BF).
//  - dh=dl=1 on every step: sar_err flips 10 times; code=0.
//  - SOC toggled again 10 cycles into CONV: sar_warn flips once.
//    First result is unchanged; no second eoc flip.
//  - atpg=1 during conversion: sample/clock/sw/swb=0; sar_eoc still flips.
//  - rstb pulse mid-CONV: outputs 0; a fresh SOC then converts normally.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types, default sizing and counter-width helpers for the SAR ADC controller.
package sar_pkg;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} sar_state_t;

  localparam int unsigned NSTEP_DFLT     = 10;
  localparam int unsigned STEP_SIZE_DFLT = 4;

  function automatic int unsigned step_cnt_w(input int unsigned nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

  function automatic int unsigned cyc_cnt_w(input int unsigned step_size);
    return (step_size > 1) ? $clog2(step_size) : 1;
  endfunction

endpackage

// File: rtl/sar_toggle_sync.sv
// Two-flop synchroniser for a toggle-coded request; emits a registered one-cycle pulse per toggle.
module sar_toggle_sync (
  input  logic f100m_clk,
  input  logic rstb,
  input  logic tgl_i,
  output logic pulse_o
);

  logic [2:0] sync_q;
  logic       pulse_q;

  always_ff @(posedge f100m_clk or negedge rstb) begin
    if (!rstb) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], tgl_i};
      pulse_q <= sync_q[1] ^ sync_q[2];
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion controller: toggle-coded SOC in, binary search over the analog macro,
// toggle-coded EOC/error/warning events out.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned NSTEP     = NSTEP_DFLT,
  parameter int unsigned STEP_SIZE = STEP_SIZE_DFLT
) (
  input  logic             f100m_clk,
  input  logic             rstb,
  input  logic             atpg,
  input  logic             sar_soc,
  output logic             sar_eoc,
  output logic             sar_err,
  output logic             sar_warn,
  output logic [NSTEP-1:0] sar_code,
  input  logic             ms_sar_dh,
  input  logic             ms_sar_dl,
  input  logic             ms_sar_rdy,
  output logic             ms_sar_clock,
  output logic             ms_sar_sample,
  output logic [NSTEP-1:0] ms_sar_sw,
  output logic [NSTEP-1:0] ms_sar_swb
);

  localparam int unsigned STEP_W = step_cnt_w(NSTEP);
  localparam int unsigned CYC_W  = cyc_cnt_w(STEP_SIZE);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(STEP_SIZE - 1);
  localparam logic [CYC_W-1:0]  CLK_HI   = CYC_W'(STEP_SIZE / 2);
  localparam logic [STEP_W-1:0] K_MSB    = STEP_W'(NSTEP - 1);

  sar_state_t        state_q, state_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] k_q, k_d;
  logic [NSTEP-1:0]  res_q, res_d;
  logic [NSTEP-1:0]  code_q, code_d;
  logic [NSTEP-1:0]  sw_q, sw_d, swb_q, swb_d;
  logic              eoc_q, eoc_d, err_q, err_d, warn_q, warn_d;
  logic              aclk_q, aclk_d, samp_q, samp_d;
  logic              start_c, warn_ev_c;

  sar_toggle_sync u_soc_sync (
    .f100m_clk (f100m_clk),
    .rstb      (rstb),
    .tgl_i     (sar_soc),
    .pulse_o   (start_c)
  );

  always_ff @(posedge f100m_clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      res_q   <= '0;
      code_q  <= '0;
      sw_q    <= '0;
      swb_q   <= '0;
      eoc_q   <= 1'b0;
      err_q   <= 1'b0;
      warn_q  <= 1'b0;
      aclk_q  <= 1'b0;
      samp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      res_q   <= res_d;
      code_q  <= code_d;
      sw_q    <= sw_d;
      swb_q   <= swb_d;
      eoc_q   <= eoc_d;
      err_q   <= err_d;
      warn_q  <= warn_d;
      aclk_q  <= aclk_d;
      samp_q  <= samp_d;
    end
  end

  // Trial bit of the next step is set on the same edge that resolves the current one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    res_d     = res_q;
    code_d    = code_q;
    eoc_d     = eoc_q;
    err_d     = err_q;
    warn_ev_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = SAMPLE;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == CYC_LAST) begin
          state_d      = CONV;
          cnt_d        = '0;
          k_d          = K_MSB;
          res_d[K_MSB] = 1'b1;
        end else begin
          cnt_d = cnt_q + CYC_W'(1);
        end
      end
      CONV: begin
        if (cnt_q == CYC_LAST) begin
          if (!ms_sar_rdy) begin
            warn_ev_c  = 1'b1;
            res_d[k_q] = 1'b0;
          end else if (ms_sar_dh == ms_sar_dl) begin
            err_d      = ~err_q;
            res_d[k_q] = 1'b0;
          end else begin
            res_d[k_q] = ms_sar_dh;
          end
          cnt_d = '0;
          if (k_q == '0) begin
            state_d = DONE;
          end else begin
            k_d                       = k_q - STEP_W'(1);
            res_d[k_q - STEP_W'(1)]   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CYC_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        code_d  = res_q;
        eoc_d   = ~eoc_q;
      end
      default: state_d = IDLE;
    endcase

    if (start_c && state_q != IDLE) warn_ev_c = 1'b1;
    warn_d = warn_q ^ warn_ev_c;

    // Analog-facing controls follow the next state so they align with it; scan mode forces them low.
    samp_d = (state_d == SAMPLE) && !atpg;
    aclk_d = (state_d == CONV) && (cnt_d >= CYC_W'(1)) && (cnt_d <= CLK_HI) && !atpg;
    sw_d   = ((state_d == CONV) && !atpg) ? res_d  : '0;
    swb_d  = ((state_d == CONV) && !atpg) ? ~res_d : '0;
  end

  assign sar_eoc       = eoc_q;
  assign sar_err       = err_q;
  assign sar_warn      = warn_q;
  assign sar_code      = code_q;
  assign ms_sar_clock  = aclk_q;
  assign ms_sar_sample = samp_q;
  assign ms_sar_sw     = sw_q;
  assign ms_sar_swb    = swb_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: randomized analog input levels against an ideal
// binary-search reference, plus directed comparator-fault, SOC-overlap, scan and reset cases.
module tb_sar_adc_ctrl;

  localparam int NSTEP = 10;
  localparam int LAT   = 49;

  logic             f100m_clk = 1'b0;
  logic             rstb      = 1'b0;
  logic             atpg      = 1'b0;
  logic             sar_soc   = 1'b0;
  logic             sar_eoc, sar_err, sar_warn;
  logic [NSTEP-1:0] sar_code;
  logic             ms_sar_dh, ms_sar_dl, ms_sar_rdy;
  logic             ms_sar_clock, ms_sar_sample;
  logic [NSTEP-1:0] ms_sar_sw, ms_sar_swb;

  int n_cmp = 0;
  int n_mis = 0;
  int mode  = 0;
  int vin   = 0;

  sar_adc_ctrl dut (
    .f100m_clk     (f100m_clk),
    .rstb          (rstb),
    .atpg          (atpg),
    .sar_soc       (sar_soc),
    .sar_eoc       (sar_eoc),
    .sar_err       (sar_err),
    .sar_warn      (sar_warn),
    .sar_code      (sar_code),
    .ms_sar_dh     (ms_sar_dh),
    .ms_sar_dl     (ms_sar_dl),
    .ms_sar_rdy    (ms_sar_rdy),
    .ms_sar_clock  (ms_sar_clock),
    .ms_sar_sample (ms_sar_sample),
    .ms_sar_sw     (ms_sar_sw),
    .ms_sar_swb    (ms_sar_swb)
  );

  always #5 f100m_clk = ~f100m_clk;

  // Comparator behaviour: 0 always-high, 1 ideal (input at vin+0.5 LSB), 2 not-ready on bit 6 trial, 3 dh=dl.
  always_comb begin
    ms_sar_dh  = 1'b1;
    ms_sar_dl  = 1'b0;
    ms_sar_rdy = 1'b1;
    case (mode)
      1: begin
        ms_sar_dh = (2 * int'(ms_sar_sw)) < (2 * vin + 1);
        ms_sar_dl = ~ms_sar_dh;
      end
      2: if (ms_sar_sw[6] && ms_sar_sw[5:0] == 6'd0) ms_sar_rdy = 1'b0;
      3: ms_sar_dl = 1'b1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " flags"}, 32'({sar_eoc, sar_err, sar_warn, ms_sar_clock, ms_sar_sample}), 32'd0);
    chk({tag, " code"}, 32'(sar_code), 32'd0);
    chk({tag, " sw"}, 32'({ms_sar_sw, ms_sar_swb}), 32'd0);
  endtask

  // Ideal trial pattern on step s: resolved upper bits of the answer plus the trial bit.
  function automatic logic [NSTEP-1:0] exp_trial(input int code, input int s);
    int k;
    int m;
    k = NSTEP - 1 - s;
    m = (code & ~((1 << (k + 1)) - 1)) | (1 << k);
    return NSTEP'(m);
  endfunction

  task automatic run_conv(input string tag, input int exp_code, input int exp_err,
                          input int exp_warn, input int extra_cyc, input bit chk_sw,
                          input bit chk_off);
    logic             eoc0, err_p, warn_p, clk_p, eoc1;
    int               cyc, errs, warns, samp, bad_swb, bad_off, eoc_extra;
    bit               done;
    logic [NSTEP-1:0] swq[$];
    eoc0 = sar_eoc; err_p = sar_err; warn_p = sar_warn; clk_p = 1'b0;
    cyc = 0; errs = 0; warns = 0; samp = 0; bad_swb = 0; bad_off = 0; eoc_extra = 0;
    done = 1'b0;
    @(negedge f100m_clk);
    sar_soc = ~sar_soc;
    while (!done && cyc < 200) begin
      @(posedge f100m_clk);
      #1;
      cyc++;
      if (cyc == extra_cyc) sar_soc = ~sar_soc;
      if (sar_err != err_p) errs++;
      if (sar_warn != warn_p) warns++;
      err_p = sar_err; warn_p = sar_warn;
      if (ms_sar_sample) samp++;
      if (ms_sar_clock && !clk_p) swq.push_back(ms_sar_sw);
      clk_p = ms_sar_clock;
      if (ms_sar_clock && ms_sar_swb !== ~ms_sar_sw) bad_swb++;
      if (ms_sar_sample || ms_sar_clock || (|ms_sar_sw) || (|ms_sar_swb)) bad_off++;
      if (sar_eoc != eoc0) done = 1'b1;
    end
    chk({tag, " eoc latency"}, 32'(cyc), 32'(LAT));
    chk({tag, " code"}, 32'(sar_code), 32'(exp_code));
    chk({tag, " err flips"}, 32'(errs), 32'(exp_err));
    chk({tag, " warn flips"}, 32'(warns), 32'(exp_warn));
    if (chk_off) chk({tag, " analog forced off"}, 32'(bad_off), 32'd0);
    else         chk({tag, " sample cycles"}, 32'(samp), 32'd4);
    if (extra_cyc > 0) begin
      eoc1 = sar_eoc;
      repeat (100) begin
        @(posedge f100m_clk);
        #1;
        if (sar_eoc != eoc1) eoc_extra++;
        eoc1 = sar_eoc;
      end
      chk({tag, " no second eoc"}, 32'(eoc_extra), 32'd0);
      chk({tag, " code held"}, 32'(sar_code), 32'(exp_code));
    end
    if (chk_sw) begin
      chk({tag, " step count"}, 32'(swq.size()), 32'(NSTEP));
      for (int s = 0; s < NSTEP && s < swq.size(); s++)
        chk($sformatf("%s sw step %0d", tag, s), 32'(swq[s]), 32'(exp_trial(exp_code, s)));
      chk({tag, " swb complement"}, 32'(bad_swb), 32'd0);
    end
  endtask

  initial begin
    int idle_act;
    logic eoc0;

    #1;
    chk_outputs_zero("reset");
    repeat (3) @(negedge f100m_clk);
    rstb = 1'b1;
    idle_act = 0;
    repeat (30) begin
      @(posedge f100m_clk);
      #1;
      if (sar_eoc || sar_err || sar_warn || ms_sar_sample || ms_sar_clock || (|ms_sar_sw)) idle_act++;
    end
    chk("idle after reset", 32'(idle_act), 32'd0);

    mode = 0;
    run_conv("always_high", 'h3FF, 0, 0, 0, 1'b0, 1'b0);

    mode = 1; vin = 512;
    run_conv("zero_diff", 'h200, 0, 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      vin = int'($urandom_range(0, 1023));
      run_conv($sformatf("rand%0d_vin%0d", i, vin), vin, 0, 0, 0, 1'b1, 1'b0);
    end

    mode = 2;
    run_conv("rdy_low_step3", 'h3BF, 0, 1, 0, 1'b0, 1'b0);

    mode = 3;
    run_conv("dh_eq_dl", 'h000, 10, 0, 0, 1'b0, 1'b0);

    mode = 0; atpg = 1'b1;
    run_conv("atpg", 'h3FF, 0, 0, 0, 1'b0, 1'b1);
    atpg = 1'b0;

    mode = 1; vin = int'($urandom_range(0, 1000));
    run_conv("rand_pre_overlap", vin, 0, 0, 0, 1'b1, 1'b0);

    mode = 0;
    run_conv("soc_overlap", 'h3FF, 0, 1, 18, 1'b0, 1'b0);

    // Reset in the middle of a conversion must abort it without an EOC event.
    mode = 1; vin = 300;
    @(negedge f100m_clk);
    sar_soc = ~sar_soc;
    repeat (20) @(posedge f100m_clk);
    @(negedge f100m_clk);
    rstb = 1'b0;
    sar_soc = 1'b0;
    #1;
    chk_outputs_zero("mid_conv_reset");
    repeat (3) @(negedge f100m_clk);
    rstb = 1'b1;
    eoc0 = sar_eoc;
    idle_act = 0;
    repeat (80) begin
      @(posedge f100m_clk);
      #1;
      if (sar_eoc != eoc0 || ms_sar_sample || ms_sar_clock) idle_act++;
    end
    chk("no eoc after abort", 32'(idle_act), 32'd0);

    vin = int'($urandom_range(0, 1023));
    run_conv("post_reset", vin, 0, 0, 0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
